// File: rtl/spi.sv
// -----------------------------------------------------------------------------
// spi: full-duplex SPI master, mode 0 (CPOL=0, CPHA=0), MSB first, one
// W_DATA-bit word per transfer. No chip select; slave selection is external.
//
// Parameters
//   W_DATA  : word width in bits (>= 2)
//   CLK_DIV : spi_clk half-period in clk cycles (>= 1)
//
// Ports
//   rst                 : synchronous, active-high reset
//   clk                 : system clock, rising edge
//   mosi_data           : word to transmit, captured when a request is accepted
//   data_transmit_valid : start request
//   miso_data           : last fully received word, held until the next completion
//   data_in_valid       : one-cycle pulse, miso_data has just been updated
//   miso_in             : serial data from the slave, sampled on spi_clk rise
//   spi_clk             : serial clock, idles low
//   mosi_out            : serial data to the slave, changes on spi_clk fall
//
// Handshake: data_transmit_valid is a request strobe with an implicit ready
// that is high only in IDLE. A request is accepted at a rising clk edge where
// data_transmit_valid=1 and the block is IDLE; requests seen during XFER
// (including the completing edge) are dropped, never queued. data_in_valid
// has no back-pressure: it is high for exactly one cycle per completed word.
// -----------------------------------------------------------------------------
module spi #(
    parameter int W_DATA  = 32,
    parameter int CLK_DIV = 1
) (
    input  logic              rst,
    input  logic              clk,
    input  logic [W_DATA-1:0] mosi_data,
    input  logic              data_transmit_valid,
    output logic [W_DATA-1:0] miso_data,
    output logic              data_in_valid,
    input  logic              miso_in,
    output logic              spi_clk,
    output logic              mosi_out
);

    localparam int W_DIV = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int W_BIT = (W_DATA > 1) ? $clog2(W_DATA) : 1;
    localparam logic [W_DIV-1:0] DIV_LAST = W_DIV'(CLK_DIV - 1);
    localparam logic [W_BIT-1:0] BIT_LAST = W_BIT'(W_DATA - 1);

    typedef enum logic {
        IDLE = 1'b0,
        XFER = 1'b1
    } state_t;

    // state_q is the FSM state; checkers bind to it directly.
    state_t state_q, state_d;

    logic [W_DATA-1:0] tx_q, tx_d;
    logic [W_DATA-1:0] rx_q, rx_d;
    logic [W_DIV-1:0]  div_q, div_d;
    logic [W_BIT-1:0]  bit_q, bit_d;
    logic [W_DATA-1:0] miso_data_d;
    logic              data_in_valid_d;
    logic              spi_clk_d;
    logic              mosi_out_d;

    logic tick;      // divider wraps this cycle: spi_clk toggles at this edge
    logic rise;      // this edge drives spi_clk 0 -> 1
    logic fall;      // this edge drives spi_clk 1 -> 0
    logic last_bit;

    assign tick     = (state_q == XFER) && (div_q == DIV_LAST);
    assign rise     = tick && !spi_clk;
    assign fall     = tick && spi_clk;
    assign last_bit = (bit_q == BIT_LAST);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (data_transmit_valid) state_d = XFER;
            XFER:    if (fall && last_bit)    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output / datapath next values (all outputs are registered below)
    always_comb begin
        tx_d            = tx_q;
        rx_d            = rx_q;
        div_d           = div_q;
        bit_d           = bit_q;
        miso_data_d     = miso_data;
        data_in_valid_d = 1'b0;
        spi_clk_d       = spi_clk;
        mosi_out_d      = mosi_out;
        case (state_q)
            IDLE: begin
                spi_clk_d = 1'b0;
                if (data_transmit_valid) begin
                    tx_d       = mosi_data;
                    mosi_out_d = mosi_data[W_DATA-1];
                    div_d      = '0;
                    bit_d      = '0;
                end
            end
            XFER: begin
                div_d = tick ? '0 : div_q + W_DIV'(1);
                if (tick) spi_clk_d = !spi_clk;
                if (rise) rx_d = {rx_q[W_DATA-2:0], miso_in};
                if (fall) begin
                    if (!last_bit) begin
                        // Rotate rather than shift: the bit leaving the top
                        // has already been driven, so recirculating it costs
                        // nothing and keeps every register bit live.
                        tx_d       = {tx_q[W_DATA-2:0], tx_q[W_DATA-1]};
                        mosi_out_d = tx_q[W_DATA-2];
                        bit_d      = bit_q + W_BIT'(1);
                    end else begin
                        miso_data_d     = rx_q;
                        data_in_valid_d = 1'b1;
                        mosi_out_d      = 1'b0;
                    end
                end
            end
            default: begin
                spi_clk_d  = 1'b0;
                mosi_out_d = 1'b0;
            end
        endcase
    end

    // Datapath / output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            tx_q          <= '0;
            rx_q          <= '0;
            div_q         <= '0;
            bit_q         <= '0;
            miso_data     <= '0;
            data_in_valid <= 1'b0;
            spi_clk       <= 1'b0;
            mosi_out      <= 1'b0;
        end else begin
            tx_q          <= tx_d;
            rx_q          <= rx_d;
            div_q         <= div_d;
            bit_q         <= bit_d;
            miso_data     <= miso_data_d;
            data_in_valid <= data_in_valid_d;
            spi_clk       <= spi_clk_d;
            mosi_out      <= mosi_out_d;
        end
    end

endmodule

// File: tb/tb_spi.sv
// -----------------------------------------------------------------------------
// tb_spi: self-checking bench for spi. Two instances: dut_a (CLK_DIV=1) and
// dut_b (CLK_DIV=3). sel picks which one is driven and observed. Expected
// words are pushed to exp_q when a request is driven and popped when
// data_in_valid is seen.
// -----------------------------------------------------------------------------
module tb_spi;

    localparam int W = 32;

    // Clock / reset
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // Shared stimulus
    logic [W-1:0] drv_data;
    logic         drv_valid;
    logic         drv_miso;
    logic         loop_en;
    logic         sel;

    // DUT A (CLK_DIV=1)
    logic [W-1:0] miso_data_a;
    logic         dv_a, sclk_a, mosi_a, miso_a, valid_a;
    // DUT B (CLK_DIV=3)
    logic [W-1:0] miso_data_b;
    logic         dv_b, sclk_b, mosi_b, miso_b, valid_b;

    assign valid_a = drv_valid & ~sel;
    assign valid_b = drv_valid & sel;
    assign miso_a  = loop_en ? mosi_a : drv_miso;
    assign miso_b  = loop_en ? mosi_b : drv_miso;

    spi #(.W_DATA(W), .CLK_DIV(1)) dut_a (
        .rst(rst), .clk(clk), .mosi_data(drv_data), .data_transmit_valid(valid_a),
        .miso_data(miso_data_a), .data_in_valid(dv_a), .miso_in(miso_a),
        .spi_clk(sclk_a), .mosi_out(mosi_a)
    );

    spi #(.W_DATA(W), .CLK_DIV(3)) dut_b (
        .rst(rst), .clk(clk), .mosi_data(drv_data), .data_transmit_valid(valid_b),
        .miso_data(miso_data_b), .data_in_valid(dv_b), .miso_in(miso_b),
        .spi_clk(sclk_b), .mosi_out(mosi_b)
    );

    // Observed (selected) DUT
    logic [W-1:0] ob_miso_data;
    logic         ob_dv, ob_sclk, ob_mosi;
    assign ob_miso_data = sel ? miso_data_b : miso_data_a;
    assign ob_dv        = sel ? dv_b : dv_a;
    assign ob_sclk      = sel ? sclk_b : sclk_a;
    assign ob_mosi      = sel ? mosi_b : mosi_a;

    // Scoreboard
    logic [W-1:0] exp_q[$];
    int checks = 0;
    int errors = 0;
    int n_exp  = 0;
    int dv_total = 0;

    always @(negedge clk) dv_total <= dv_total + int'(dv_a) + int'(dv_b);

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drive one request (called at a negedge) and follow the transfer to its
    // completion, checking spi_clk edge timing against the T0 formulas.
    task automatic run_xfer(input logic [W-1:0] data, input logic [W-1:0] exp,
                            input int busy_at, input logic hold_en,
                            input logic [W-1:0] hold_val);
        int div = sel ? 3 : 1;
        int lat = 2 * W * div;
        int n = 0, rises = 0, falls = 0, terr = 0, herr = 0;
        logic prev = 1'b0;
        logic [W-1:0] sh = '0;
        logic [W-1:0] got;
        drv_data  = data;
        drv_valid = 1'b1;
        exp_q.push_back(exp);
        n_exp++;
        @(negedge clk);
        drv_valid = 1'b0;
        check("dv_low_after_accept", {31'd0, ob_dv}, 32'd0);
        while (!ob_dv && n < lat + 10) begin
            @(negedge clk);
            n++;
            if (busy_at != 0 && n == busy_at) begin
                drv_data  = 32'hDEADBEEF;
                drv_valid = 1'b1;
            end
            if (busy_at != 0 && n == busy_at + 1) drv_valid = 1'b0;
            if (ob_sclk && !prev) begin
                if (n != (2 * rises + 1) * div) terr++;
                sh = {sh[W-2:0], ob_mosi};
                rises++;
            end
            if (!ob_sclk && prev) begin
                if (n != (2 * falls + 2) * div) terr++;
                falls++;
            end
            prev = ob_sclk;
            if (hold_en && !ob_dv && ob_miso_data !== hold_val) herr++;
        end
        check("latency", n, lat);
        check("sclk_rises", rises, W);
        check("sclk_timing", terr, 0);
        if (loop_en) check("mosi_msb_first", sh, data);
        if (hold_en) check("miso_hold", herr, 0);
        got = exp_q.pop_front();
        if (ob_dv) check("rx_data", ob_miso_data, got);
        else       check("dv_timeout", {31'd0, ob_dv}, 32'd1);
    endtask

    initial begin : main
        int cnt;
        rst       = 1'b1;
        sel       = 1'b0;
        loop_en   = 1'b0;
        drv_valid = 1'b0;
        drv_data  = '0;
        drv_miso  = 1'b0;

        // Reset with random inputs
        repeat (2) begin
            @(negedge clk);
            drv_data  = $urandom;
            drv_miso  = 1'($urandom_range(0, 1));
            drv_valid = 1'($urandom_range(0, 1));
        end
        @(negedge clk);
        check("rst_sclk_a", {31'd0, sclk_a}, 32'd0);
        check("rst_mosi_a", {31'd0, mosi_a}, 32'd0);
        check("rst_dv_a", {31'd0, dv_a}, 32'd0);
        check("rst_miso_data_a", miso_data_a, 32'h0);
        check("rst_sclk_b", {31'd0, sclk_b}, 32'd0);
        check("rst_miso_data_b", miso_data_b, 32'h0);
        drv_valid = 1'b0;
        rst       = 1'b0;
        @(negedge clk);

        // Loopback
        loop_en = 1'b1;
        run_xfer(32'hA5A50F0F, 32'hA5A50F0F, 0, 1'b0, '0);

        // Constant MISO, second transfer back-to-back
        loop_en  = 1'b0;
        drv_miso = 1'b1;
        run_xfer(32'h3C3C_1234, 32'hFFFFFFFF, 0, 1'b0, '0);
        drv_miso = 1'b0;
        run_xfer(32'h0F1E_2D3C, 32'h00000000, 0, 1'b1, 32'hFFFFFFFF);

        // Busy: second request at cycle 10 ignored, then back-to-back start
        loop_en = 1'b1;
        run_xfer(32'h12345678, 32'h12345678, 10, 1'b0, '0);
        run_xfer(32'h5A5AF00D, 32'h5A5AF00D, 0, 1'b0, '0);

        // Reset mid-transfer
        @(negedge clk);
        drv_data  = 32'h6B6B_7C7C;
        drv_valid = 1'b1;
        @(negedge clk);
        drv_valid = 1'b0;
        repeat (19) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("abort_sclk", {31'd0, sclk_a}, 32'd0);
        check("abort_mosi", {31'd0, mosi_a}, 32'd0);
        check("abort_miso_data", miso_data_a, 32'h0);
        rst = 1'b0;
        cnt = 0;
        repeat (80) begin
            @(negedge clk);
            if (dv_a) cnt++;
        end
        check("abort_no_dv", cnt, 0);

        // Request held high through reset: accepted at first edge after release
        rst       = 1'b1;
        drv_data  = 32'hC3C35A5A;
        drv_valid = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        run_xfer(32'hC3C35A5A, 32'hC3C35A5A, 0, 1'b0, '0);

        // CLK_DIV=3 loopback
        @(negedge clk);
        sel = 1'b1;
        run_xfer(32'h80000001, 32'h80000001, 0, 1'b0, '0);

        repeat (4) @(negedge clk);
        check("dv_count", dv_total, n_exp);
        check("queue_empty", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
